// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display BCD conversion path.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_L,
        SHIFT_S,
        COMMIT
    } state_t;

    localparam int unsigned BCD_W        = 4;
    localparam int unsigned LIVES_BITS   = 4;
    localparam int unsigned SCORE_BITS   = 10;
    localparam int unsigned CONV_LATENCY = 16;

    localparam logic [BCD_W-1:0] BLANK_CODE_DEF = 4'hF;

endpackage

// File: rtl/bcd_add3_step.sv
// One double-dabble step: add 3 to every nibble >= 5, then shift left taking bit_in as the new LSB.
module bcd_add3_step
    import score_disp_pkg::*;
#(
    parameter int unsigned NIB = 4
) (
    input  logic [NIB*BCD_W-1:0] bcd_in,
    input  logic                 bit_in,
    output logic [NIB*BCD_W-1:0] bcd_out
);

    logic [NIB*BCD_W-1:0] adj;

    // Per-nibble 4-bit add; any carry out of a nibble is discarded.
    always_comb begin
        adj = bcd_in;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (bcd_in[i*BCD_W +: BCD_W] >= 4'd5)
                adj[i*BCD_W +: BCD_W] = bcd_in[i*BCD_W +: BCD_W] + 4'd3;
        end
        bcd_out = {adj[NIB*BCD_W-2:0], bit_in};
    end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential lives/score binary-to-BCD converter driving the four 7-segment digits.
// Optional macro LEADING_BLANK_EN blanks zero tens digits with BLANK_CODE.
module score_bcd_converter
    import score_disp_pkg::*;
#(
    parameter int               AUTO_REFRESH   = 1,
    parameter int unsigned      REFRESH_CYCLES = 1000000,
    parameter logic [BCD_W-1:0] BLANK_CODE     = BLANK_CODE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SCORE_BITS-1:0] score,
    input  logic [LIVES_BITS-1:0] lives,
    output logic                  busy,
    output logic                  done,
    output logic [BCD_W-1:0]      digitL,
    output logic [BCD_W-1:0]      digitML,
    output logic [BCD_W-1:0]      digitMR,
    output logic [BCD_W-1:0]      digitR,
    output logic                  score_ovf
);

    state_t                          state;
    logic [23:0]                     timer;
    logic                            tick;
    logic                            trig;
    logic                            pend;
    logic [$clog2(CONV_LATENCY)-1:0] cnt;
    logic [SCORE_BITS-1:0]           bin;
    logic [SCORE_BITS-1:0]           snap_score;
    logic [4*BCD_W-1:0]              acc;
    logic [4*BCD_W-1:0]              step;
    logic [2*BCD_W-1:0]              lives_bcd;

    assign tick = (timer == 24'(REFRESH_CYCLES - 1));
    assign trig = start | ((AUTO_REFRESH != 0) & tick);

    // Lives run through the same 4-nibble engine with the upper nibbles held at zero.
    bcd_add3_step #(.NIB(4)) u_step (
        .bcd_in  (acc),
        .bit_in  (bin[SCORE_BITS-1]),
        .bcd_out (step)
    );

`ifndef LEADING_BLANK_EN
    logic unused_blank;
    assign unused_blank = ^BLANK_CODE;
`endif

    // trig is captured into pend with the snapshot; the FSM leaves IDLE one edge later,
    // so busy spans 15 cycles and digits land 16 edges after the sampling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            pend       <= 1'b0;
            cnt        <= '0;
            bin        <= '0;
            snap_score <= '0;
            acc        <= '0;
            lives_bcd  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            digitL     <= '0;
            digitML    <= '0;
            digitMR    <= '0;
            digitR     <= '0;
            score_ovf  <= 1'b0;
        end else begin
            timer <= tick ? '0 : timer + 24'd1;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend) begin
                        pend  <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT_L;
                    end else if (trig) begin
                        pend       <= 1'b1;
                        snap_score <= score;
                        bin        <= {lives, {(SCORE_BITS-LIVES_BITS){1'b0}}};
                    end
                end
                SHIFT_L: begin
                    acc <= step;
                    bin <= bin << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == 4'd3) begin
                        lives_bcd <= step[2*BCD_W-1:0];
                        acc       <= '0;
                        bin       <= snap_score;
                        cnt       <= '0;
                        state     <= SHIFT_S;
                    end
                end
                SHIFT_S: begin
                    acc <= step;
                    bin <= bin << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == 4'd9)
                        state <= COMMIT;
                end
                COMMIT: begin
`ifdef LEADING_BLANK_EN
                    digitL  <= (lives_bcd[7:4] == '0) ? BLANK_CODE : lives_bcd[7:4];
                    digitMR <= (acc[7:4] == '0 && acc[15:8] == '0) ? BLANK_CODE : acc[7:4];
`else
                    digitL  <= lives_bcd[7:4];
                    digitMR <= acc[7:4];
`endif
                    digitML   <= lives_bcd[3:0];
                    digitR    <= acc[3:0];
                    score_ovf <= |acc[15:8];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/score_bcd_converter.md
Name: score_bcd_converter

Overview:
- Sequential binary-to-BCD stage feeding the 7-segment controller's four digit inputs (digitL, digitML, digitMR, digitR).
- Replaces the combinational divide/modulo digit logic in the game top.
- One shared shift-add-3 (double-dabble) engine converts lives, then score, from a snapshot taken at start.
- Commits all four digits atomically.

Parameters:
- AUTO_REFRESH, 1, when 1 an internal timer issues a start pulse every REFRESH_CYCLES clocks; when 0 only the start port triggers.
- REFRESH_CYCLES, 1000000, refresh period in clk cycles; legal range 17..2^24-1.
- BLANK_CODE, 4'hF, digit value the segment controller renders as blank.

Ports:
- clk  in  1  master clock, 50 MHz
- rst  in  1  synchronous active-high reset
- start  in  1  request one conversion; sampled only when busy=0
- score  in  10  binary score, 0..1023
- lives  in  4  binary lives, 0..15
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse on the cycle digits update
- digitL  out  4  lives tens (0 or 1)
- digitML  out  4  lives ones
- digitMR  out  4  score tens (score mod 100)
- digitR  out  4  score ones
- score_ovf  out  1  score snapshot was >= 100 (hundreds or thousands nonzero)

Behaviour:
- Reset values: all digits 0, busy=0, done=0, score_ovf=0, refresh timer=0, FSM=IDLE. Reset mid-conversion aborts; digits keep no partial result.
- Trigger: trig = start | (AUTO_REFRESH & timer_tick).
  - timer_tick is high for one cycle when the timer reaches REFRESH_CYCLES-1; the timer then wraps to 0.
  - The timer free-runs, including while busy.
- FSM:
  - IDLE: on trig, snapshot score/lives, load the lives shift register, cnt=0, busy=1, go to SHIFT_L. Otherwise stay.
  - SHIFT_L: 4 cycles. Each cycle, add 3 to any BCD nibble >= 5, then shift left 1 with the MSB of the binary word entering the BCD LSB. After cnt=3, load the score register, cnt=0, go to SHIFT_S.
  - SHIFT_S: 10 cycles, same step on a 16-bit BCD accumulator (thousands, hundreds, tens, ones). After cnt=9, go to COMMIT.
  - COMMIT: one cycle. Write digitL/ML from the lives BCD and digitMR/R from the score tens/ones. Set score_ovf, done=1 for this cycle, busy=0, return to IDLE.
- Latency: the edge sampling trig is edge 0; digits, done and busy-fall all change on edge 16. busy is high for 15 cycles.
- A new trig is accepted in the cycle after COMMIT at the earliest. start asserted while busy or in COMMIT is dropped (not queued).
- Snapshot rule: score/lives changes during busy do not affect the result in flight.
- The nibble-correction add is 4-bit, with no carry between nibbles. The >=5 test is done before the shift.
- Digits never glitch: between commits they hold their previous values.
- The game top must drive start on every score or lives change, or set AUTO_REFRESH=1.

Optional Feature:
- Macro: LEADING_BLANK_EN.
- Defined:
  - At COMMIT, digitL = BLANK_CODE when the lives tens digit = 0.
  - digitMR = BLANK_CODE when the score tens digit = 0 and score_ovf = 0.
  - Ones digits are never blanked.
- Undefined: zeros are shown as 0; BLANK_CODE is unused.

Decomposition:
- Shared package score_disp_pkg holds:
  - the FSM state enum (IDLE, SHIFT_L, SHIFT_S, COMMIT);
  - BCD_W=4, LIVES_BITS=4, SCORE_BITS=10, CONV_LATENCY=16;
  - the default BLANK_CODE.
- One natural sub-module: bcd_add3_step, combinational. It takes an N-nibble BCD value and the next binary bit, and returns the corrected, shifted value. One instance is reused for both phases, with the lives phase zero-padded.

Test Plan:
- Reset, then start with score=37, lives=2 → done on edge 16; digits 0,2,3,7; score_ovf=0; busy high for exactly 15 cycles.
- score=1023, lives=15 → digits 1,5,2,3; score_ovf=1.
- score=0, lives=0:
  - with LEADING_BLANK_EN → digitL=F, digitML=0, digitMR=F, digitR=0;
  - without it → all 0.
- Start with score=45, then change score to 99 and pulse start at edge 5 → result 45 only; one done pulse; a later start yields 99.
- Assert rst at edge 8 of a conversion → busy=0, done never pulses, digits 0. A following start converts normally with 16-edge latency.
- AUTO_REFRESH=1, REFRESH_CYCLES=40, start tied 0, score=12, lives=3 → done every 40 cycles; the first digits are 0,3,1,2 at 56 cycles after reset release.
